// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC array and its result drain.
package mac_pkg;

  localparam int MAC_ACC_WIDTH = 24;
  localparam int MAC_LANES     = 8;

  typedef logic [MAC_ACC_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } drain_state_t;

endpackage

// File: rtl/mac_result_drain_if.sv
// Valid/ready result stream carrying one drained MAC row per beat.
interface mac_result_drain_if #(
  parameter int OUT_WIDTH = 24,
  parameter int IDX_WIDTH = 3
);

  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0] out_idx;
  logic                 out_sat;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_sat,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_sat,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mac_sat_trunc.sv
// Unsigned narrowing of an accumulator to the stream width, clamping to all-ones on overflow.
module mac_sat_trunc #(
  parameter int ACC_WIDTH = 24,
  parameter int OUT_WIDTH = 24
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat
);

  if (OUT_WIDTH == ACC_WIDTH) begin : g_pass
    assign o_data = i_acc;
    assign o_sat  = 1'b0;
  end else begin : g_sat
    logic [ACC_WIDTH-OUT_WIDTH-1:0] w_hi;

    // Any set bit above the output width means the value does not fit.
    assign w_hi   = i_acc[ACC_WIDTH-1:OUT_WIDTH];
    assign o_sat  = |w_hi;
    assign o_data = o_sat ? {OUT_WIDTH{1'b1}} : i_acc[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/mac_result_drain.sv
// Snapshots the MAC row accumulators on start, clears the array, then streams one row per beat.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_LANES,
  parameter int ACC_WIDTH  = MAC_ACC_WIDTH,
  parameter int OUT_WIDTH  = 24,
  parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] Cout [DATA_WIDTH],
  output logic                 mac_clr,
  mac_result_drain_if.master   out_if,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun
);

  if (DATA_WIDTH < 2) begin : g_chk_lanes
    $error("mac_result_drain: DATA_WIDTH must be at least 2");
  end
  if (OUT_WIDTH > ACC_WIDTH) begin : g_chk_width
    $error("mac_result_drain: OUT_WIDTH must not exceed ACC_WIDTH");
  end

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

  drain_state_t         r_state;
  drain_state_t         w_state_nxt;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [ACC_WIDTH-1:0] r_buf [DATA_WIDTH];
  logic                 r_mac_clr;
  logic                 r_err;

  logic                 w_load;
  logic                 w_adv;
  logic                 w_send;
  logic                 w_last;
  logic [OUT_WIDTH-1:0] w_sat_data;
  logic                 w_sat;

  assign w_send = (r_state == SEND);
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_if.out_ready) begin
          w_adv = 1'b1;
          if (w_last) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The clear lands one cycle after the snapshot edge, so it can never race the Cout sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_mac_clr <= 1'b0;
      r_err     <= 1'b0;
      for (int k = 0; k < DATA_WIDTH; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      r_mac_clr <= w_load;
      if (start && (r_state != IDLE)) begin
        r_err <= 1'b1;
      end
      if (w_load) begin
        r_idx <= '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
          r_buf[k] <= Cout[k];
        end
      end else if (w_adv) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  mac_sat_trunc #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .i_acc  (r_buf[r_idx]),
    .o_data (w_sat_data),
    .o_sat  (w_sat)
  );

  // Beat fields are forced to zero outside SEND so idle outputs match the reset values.
  assign out_if.out_valid = w_send;
  assign out_if.out_data  = w_send ? w_sat_data : '0;
  assign out_if.out_idx   = w_send ? r_idx : '0;
  assign out_if.out_sat   = w_send & w_sat;
  assign out_if.out_last  = w_send & w_last;

  assign mac_clr     = r_mac_clr;
  assign busy        = (r_state == SEND) || (r_state == DONE);
  assign done        = (r_state == DONE);
  assign err_overrun = r_err;

endmodule
